bcd_time_counter: RTL and testbench

- Produces the BCD time digits that the chime and alarm logic consume: hours, minutes and seconds, two BCD digits each.
- Divides the system clock down to a 1 Hz tick, counts HH:MM:SS in 24-hour format, and supports a set mode for manual adjustment.
- Sits between the board clock and every time-digit consumer: chime generator, display mux and alarm compare.

---
 rtl/bcd_time_counter.sv | 206 ++++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
//
// Purpose:
//   24-hour HH:MM:SS timekeeper with BCD digit outputs. A prescaler divides
//   clk down to a one-second tick, and the tick advances the seconds with
//   carries through minutes and hours. A SET mode (driven by set_en)
//   suppresses the tick and lets the user advance one field at a time,
//   with no carry into the other fields.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset (time becomes 00:00:00)
//   run          in   1 = timekeeping enabled, 0 = prescaler and digits hold
//   set_en       in   1 = SET mode (tick suppressed, adjustment allowed)
//   adj_sel[1:0] in   00 seconds, 01 minutes, 10 hours, 11 none
//   adj_inc      in   increment request for the selected field
//   o_hr1/o_hr0, o_min1/o_min0, o_sec1/o_sec0
//                out  BCD time digits (tens/units)
//   o_sec_tick   out  one-cycle pulse when the seconds value advances
//   o_hour_roll  out  one-cycle pulse when counting reaches xx:00:00
//
// Optional feature (macro BCD_TIME_ADJ_EDGE_EN):
//   When defined, adj_inc is treated as a raw asynchronous button level:
//   it goes through a 2-flop synchronizer and a rising-edge detector, so
//   each 0->1 transition gives exactly one increment (3-cycle latency).
//   When undefined, adj_inc is a synchronous level and every SET cycle
//   with adj_inc = 1 gives one increment (1-cycle latency).
// ---------------------------------------------------------------------------
module bcd_time_counter #(
  parameter int TICK_DIV = 100000000,
  parameter int PRE_W    = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] adj_sel,
  input  logic       adj_inc,
  output logic [3:0] o_hr1,
  output logic [3:0] o_hr0,
  output logic [3:0] o_min1,
  output logic [3:0] o_min0,
  output logic [3:0] o_sec1,
  output logic [3:0] o_sec0,
  output logic       o_sec_tick,
  output logic       o_hour_roll
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       hr1_q, hr1_d, hr0_q, hr0_d;
  logic [3:0]       min1_q, min1_d, min0_q, min0_d;
  logic [3:0]       sec1_q, sec1_d, sec0_q, sec0_d;
  logic             sec_tick_q, sec_tick_d;
  logic             hour_roll_q, hour_roll_d;

  logic             tick_int;
  logic             count_en;
  logic             adj_req;
  logic             adj_fire;

  // Advance a 00..59 BCD pair by one, wrapping 59 -> 00.
  function automatic logic [7:0] inc_mod60(input logic [3:0] tens,
                                           input logic [3:0] units);
    if (tens == 4'd5 && units == 4'd9) begin
      return 8'h00;
    end else if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, units + 4'd1};
    end
  endfunction

  // Advance a 00..23 BCD hour pair by one, wrapping 23 -> 00.
  function automatic logic [7:0] inc_hours(input logic [3:0] tens,
                                           input logic [3:0] units);
    if (tens == 4'd2 && units == 4'd3) begin
      return 8'h00;
    end else if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end else begin
      return {tens, units + 4'd1};
    end
  endfunction

`ifdef BCD_TIME_ADJ_EDGE_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Two synchronizer stages, then one more stage so a rising edge of the
  // synchronized level produces a single-cycle increment request.
  always_comb begin
    sync1_d = adj_inc;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    adj_req = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end
`else
  always_comb begin
    adj_req = adj_inc;
  end
`endif

  always_comb begin
    state_d     = set_en ? ST_SET : ST_RUN;
    pre_d       = pre_q;
    hr1_d       = hr1_q;
    hr0_d       = hr0_q;
    min1_d      = min1_q;
    min0_d      = min0_q;
    sec1_d      = sec1_q;
    sec0_d      = sec0_q;
    sec_tick_d  = 1'b0;
    hour_roll_d = 1'b0;

    tick_int = (state_q == ST_RUN) && run && (pre_q == PRE_MAX);
    // A set_en request arriving on the tick cycle drops that tick.
    count_en = tick_int && !set_en;
    adj_fire = (state_q == ST_SET) && adj_req;

    // The prescaler is held at zero while set_en is asserted, so leaving
    // SET always restarts a full one-second interval.
    if (set_en) begin
      pre_d = '0;
    end else if ((state_q == ST_RUN) && run) begin
      pre_d = tick_int ? '0 : pre_q + PRE_W'(1);
    end

    if (count_en) begin
      sec_tick_d       = 1'b1;
      {sec1_d, sec0_d} = inc_mod60(sec1_q, sec0_q);
      if (sec1_q == 4'd5 && sec0_q == 4'd9) begin
        {min1_d, min0_d} = inc_mod60(min1_q, min0_q);
        if (min1_q == 4'd5 && min0_q == 4'd9) begin
          {hr1_d, hr0_d} = inc_hours(hr1_q, hr0_q);
          hour_roll_d    = 1'b1;
        end
      end
    end else if (adj_fire) begin
      // Manual adjustment touches only the selected field.
      case (adj_sel)
        2'b00:   {sec1_d, sec0_d} = inc_mod60(sec1_q, sec0_q);
        2'b01:   {min1_d, min0_d} = inc_mod60(min1_q, min0_q);
        2'b10:   {hr1_d, hr0_d}   = inc_hours(hr1_q, hr0_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pre_q       <= '0;
      hr1_q       <= 4'd0;
      hr0_q       <= 4'd0;
      min1_q      <= 4'd0;
      min0_q      <= 4'd0;
      sec1_q      <= 4'd0;
      sec0_q      <= 4'd0;
      sec_tick_q  <= 1'b0;
      hour_roll_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      hr1_q       <= hr1_d;
      hr0_q       <= hr0_d;
      min1_q      <= min1_d;
      min0_q      <= min0_d;
      sec1_q      <= sec1_d;
      sec0_q      <= sec0_d;
      sec_tick_q  <= sec_tick_d;
      hour_roll_q <= hour_roll_d;
    end
  end

  assign o_hr1       = hr1_q;
  assign o_hr0       = hr0_q;
  assign o_min1      = min1_q;
  assign o_min0      = min0_q;
  assign o_sec1      = sec1_q;
  assign o_sec0      = sec0_q;
  assign o_sec_tick  = sec_tick_q;
  assign o_hour_roll = hour_roll_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_counter
//
// Testbench for bcd_time_counter with TICK_DIV = 4. The reference model
// keeps the time as a plain count of seconds since midnight plus a count of
// running cycles since the last tick; digits are derived by division.
// Inputs change on the falling edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_bcd_time_counter;

  localparam int TICK_DIV = 4;
  localparam int PRE_W    = 3;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_en;
  logic [1:0] adj_sel;
  logic       adj_inc;
  logic [3:0] o_hr1, o_hr0, o_min1, o_min0, o_sec1, o_sec0;
  logic       o_sec_tick;
  logic       o_hour_roll;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state
  int mSecs;
  int mCnt;
  bit mInSet;
  bit mTick;
  bit mRoll;
`ifdef BCD_TIME_ADJ_EDGE_EN
  bit mH0, mH1, mH2;
`endif

  bcd_time_counter #(
    .TICK_DIV (TICK_DIV),
    .PRE_W    (PRE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .set_en      (set_en),
    .adj_sel     (adj_sel),
    .adj_inc     (adj_inc),
    .o_hr1       (o_hr1),
    .o_hr0       (o_hr0),
    .o_min1      (o_min1),
    .o_min0      (o_min0),
    .o_sec1      (o_sec1),
    .o_sec0      (o_sec0),
    .o_sec_tick  (o_sec_tick),
    .o_hour_roll (o_hour_roll)
  );

  // 10 ns clock period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack a time and the two pulses into the same layout as the DUT outputs.
  function automatic logic [25:0] packTime(input int h, input int m, input int s,
                                           input bit t, input bit r);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), t, r};
  endfunction

  function automatic logic [25:0] dutVec();
    return {o_hr1, o_hr0, o_min1, o_min0, o_sec1, o_sec0, o_sec_tick, o_hour_roll};
  endfunction

  function automatic logic [25:0] modelVec();
    return packTime(mSecs / 3600, (mSecs / 60) % 60, mSecs % 60, mTick, mRoll);
  endfunction

  task automatic modelReset();
    mSecs  = 0;
    mCnt   = 0;
    mInSet = 1'b0;
    mTick  = 1'b0;
    mRoll  = 1'b0;
`ifdef BCD_TIME_ADJ_EDGE_EN
    mH0 = 1'b0;
    mH1 = 1'b0;
    mH2 = 1'b0;
`endif
  endtask

  // One clock edge of the model: a tick is one second after TICK_DIV
  // running cycles; an adjustment adds one unit to a single field modulo
  // its range, leaving the other fields alone.
  task automatic modelStep();
    bit accept;
    int unitVal;
    if (!rst_n) begin
      modelReset();
      return;
    end
`ifdef BCD_TIME_ADJ_EDGE_EN
    // A button press becomes an increment two edges after it is first seen.
    accept = mInSet && mH1 && !mH2;
    mH2 = mH1;
    mH1 = mH0;
    mH0 = adj_inc;
`else
    accept = mInSet && adj_inc;
`endif
    mTick = 1'b0;
    mRoll = 1'b0;
    if (set_en) begin
      mCnt = 0;
    end else if (!mInSet && run) begin
      mCnt++;
      if (mCnt == TICK_DIV) begin
        mCnt  = 0;
        mSecs = (mSecs + 1) % 86400;
        mTick = 1'b1;
        mRoll = (mSecs % 3600) == 0;
      end
    end
    if (accept) begin
      case (adj_sel)
        2'b00: begin
          unitVal = mSecs % 60;
          mSecs   = mSecs - unitVal + (unitVal + 1) % 60;
        end
        2'b01: begin
          unitVal = (mSecs / 60) % 60;
          mSecs   = mSecs + (((unitVal + 1) % 60) - unitVal) * 60;
        end
        2'b10: begin
          unitVal = mSecs / 3600;
          mSecs   = mSecs + (((unitVal + 1) % 24) - unitVal) * 3600;
        end
        default: ;
      endcase
    end
    mInSet = set_en;
  endtask

  // Compare the DUT outputs against the reference model.
  task automatic checkOutput(input string tag);
    logic [25:0] obs;
    logic [25:0] req;
    obs = dutVec();
    req = modelVec();
    vecCount++;
    assert (obs === req) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Compare the DUT outputs against a hand-computed constant.
  task automatic checkConst(input string tag, input logic [25:0] req);
    logic [25:0] obs;
    obs = dutVec();
    vecCount++;
    assert (obs === req) else begin
      missCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Drive one cycle of inputs, advance the model on the rising edge and
  // check the DUT on the following falling edge.
  task automatic applyStimulus(input bit r, input bit s, input logic [1:0] sel,
                               input bit inc);
    run     = r;
    set_en  = s;
    adj_sel = sel;
    adj_inc = inc;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkOutput("step");
  endtask

  // One increment of a field in SET mode: a one-cycle press, then enough
  // released cycles for the press to land in either adj_inc mode.
  task automatic adjField(input logic [1:0] sel, input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 1'b1, sel, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b1, sel, 1'b0);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit rr, ss, ii;
    logic [1:0] sel;

    // Power-on reset
    rst_n   = 1'b0;
    run     = 1'b0;
    set_en  = 1'b0;
    adj_sel = 2'b11;
    adj_inc = 1'b0;
    modelReset();
    #3;
    checkConst("reset_state", packTime(0, 0, 0, 0, 0));
    repeat (2) applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
    rst_n = 1'b1;

    // Counting: one tick every 4 cycles
    repeat (3) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("pre_first_tick", packTime(0, 0, 0, 0, 0));
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("first_tick", packTime(0, 0, 1, 1, 0));
    repeat (36) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("ten_ticks", packTime(0, 0, 10, 1, 0));

    // Day rollover from 23:59:59
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    adjField(2'b10, 23);
    adjField(2'b01, 59);
    adjField(2'b00, 59);
    checkConst("preload_235959", packTime(23, 59, 59, 0, 0));
    repeat (4) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("no_early_tick", packTime(23, 59, 59, 0, 0));
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("day_rollover", packTime(0, 0, 0, 1, 1));

    // Hour rollover from 00:59:59
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    adjField(2'b01, 59);
    adjField(2'b00, 59);
    repeat (5) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("hour_rollover", packTime(1, 0, 0, 1, 1));

    // Pause at 00:00:05
    doReset();
    repeat (20) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("at_5s", packTime(0, 0, 5, 1, 0));
    repeat (20) applyStimulus(1'b0, 1'b0, 2'b11, 1'b0);
    checkConst("paused", packTime(0, 0, 5, 0, 0));
    repeat (3) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    checkConst("resume_tick", packTime(0, 0, 6, 1, 0));

    // SET adjustment without carry
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    adjField(2'b01, 59);
    checkConst("set_0059", packTime(0, 59, 0, 0, 0));
    adjField(2'b01, 1);
    checkConst("min_wrap_no_carry", packTime(0, 0, 0, 0, 0));
    adjField(2'b10, 25);
    checkConst("hours_mod24", packTime(1, 0, 0, 0, 0));
    adjField(2'b11, 2);
    checkConst("sel_none", packTime(1, 0, 0, 0, 0));

    // set_en on the tick cycle drops the tick, adj_inc in RUN is ignored
    doReset();
    repeat (3) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    checkConst("set_beats_tick", packTime(0, 0, 0, 0, 0));
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    checkConst("adj_in_run", packTime(0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of a clock period at 12:34:56
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    adjField(2'b10, 12);
    adjField(2'b01, 34);
    adjField(2'b00, 56);
    checkConst("preload_123456", packTime(12, 34, 56, 0, 0));
    repeat (2) applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    @(posedge clk);
    modelStep();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkConst("async_reset", packTime(0, 0, 0, 0, 0));
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    rst_n = 1'b1;

`ifdef BCD_TIME_ADJ_EDGE_EN
    // A held button gives exactly one increment
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkConst("held_one_inc", packTime(0, 0, 1, 0, 0));
`else
    // A level held for three SET cycles gives three increments
    doReset();
    applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
    repeat (3) applyStimulus(1'b1, 1'b1, 2'b00, 1'b1);
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    checkConst("level_three_inc", packTime(0, 0, 3, 0, 0));
`endif

    // Random mix of run, SET entry/exit and adjustments
    doReset();
    ss = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rr  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) ss = ~ss;
      sel = 2'($urandom_range(0, 3));
      ii  = ($urandom_range(0, 2) == 0);
      applyStimulus(rr, ss, sel, ii);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
